// File: rtl/matrix_alu_pkg.sv
// matrix_alu_pkg
//   Shared definitions for the matrix ALU: opcode constants, FSM state
//   encoding and the element index helper used to address a flattened
//   DIM x DIM matrix bus (element (r,c) lives at index r*DIM+c).
package matrix_alu_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_MMULT  = 4'h1;
  localparam logic [3:0] OP_MSCALE = 4'h2;
  localparam logic [3:0] OP_MSUB   = 4'h3;
  localparam logic [3:0] OP_MADD   = 4'h4;
  localparam logic [3:0] OP_MTRANS = 4'h5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Linear element index of (r,c) in a dim x dim row-major matrix.
  function automatic int elem_idx(input int r, input int c, input int dim);
    return r * dim + c;
  endfunction

endpackage

// File: rtl/matrix_alu_mat_row_mult.sv
// mat_row_mult
//   Combinational row product: one row of A times the full B matrix gives
//   one row of the result. Products and running sums wrap at DW bits.
// Ports:
//   a_row_in     DIM*DW      row of A, element k at [k*DW +: DW]
//   matrix_b_in  DIM*DIM*DW  full B matrix, row-major
//   row_out      DIM*DW      result row, element c at [c*DW +: DW]
module mat_row_mult #(
  parameter int DIM = 4,
  parameter int DW  = 16
) (
  input  logic [DIM*DW-1:0]     a_row_in,
  input  logic [DIM*DIM*DW-1:0] matrix_b_in,
  output logic [DIM*DW-1:0]     row_out
);
  import matrix_alu_pkg::*;

  logic [DW-1:0] acc;

  always_comb begin
    row_out = '0;
    acc     = '0;
    for (int c = 0; c < DIM; c++) begin
      acc = '0;
      for (int k = 0; k < DIM; k++) begin
        acc = acc + a_row_in[k*DW +: DW] * matrix_b_in[elem_idx(k, c, DIM)*DW +: DW];
      end
      row_out[c*DW +: DW] = acc;
    end
  end

endmodule

// File: rtl/matrix_alu.sv
// matrix_alu
//   DIM x DIM matrix ALU with valid/ready handshakes on both sides.
//   Element-wise ops (MSCALE, MSUB, MADD, MTRANS) and illegal opcodes
//   complete in one cycle; MMULT walks one result row per cycle through a
//   single mat_row_mult instance.
// Handshake: a transfer happens on a rising edge where valid and ready are
//   both high. valid_out, matrix_result_out and err_out stay stable from
//   the moment valid_out rises until the edge where ready_in is also high.
// Ports:
//   clk_in, rst_in (sync, active-low)
//   valid_in / ready_out / opcode_in / matrix_a_in / matrix_b_in : command
//   valid_out / ready_in / matrix_result_out / err_out            : result
//   state_dbg_out : current FSM state (matrix_alu_pkg::state_e encoding)
module matrix_alu
  import matrix_alu_pkg::*;
#(
  parameter int DIM = 4,
  parameter int DW  = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [3:0]            opcode_in,
  input  logic [DIM*DIM*DW-1:0] matrix_a_in,
  input  logic [DIM*DIM*DW-1:0] matrix_b_in,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [DIM*DIM*DW-1:0] matrix_result_out,
  output logic                  err_out,
  output logic [1:0]            state_dbg_out
);

  localparam int MW = DIM * DIM * DW;
  localparam int RW = $clog2(DIM);
  localparam logic [RW-1:0] LAST_ROW = RW'(DIM - 1);

  state_e        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [3:0]    op_q, op_d;
  logic [MW-1:0] a_q, a_d;
  logic [MW-1:0] b_q, b_d;
  logic [MW-1:0] acc_q, acc_d;
  logic [MW-1:0] res_q, res_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  logic [MW-1:0]     ew_res;
  logic [DIM*DW-1:0] row_res;

  // Single shared row multiplier, steered by the row counter.
  mat_row_mult #(.DIM(DIM), .DW(DW)) u_row_mult (
    .a_row_in    (a_q[int'(row_q)*DIM*DW +: DIM*DW]),
    .matrix_b_in (b_q),
    .row_out     (row_res)
  );

  // Single-cycle ops are computed straight from the input buses so the
  // result can be registered on the accepting edge.
  always_comb begin
    ew_res = '0;
    for (int r = 0; r < DIM; r++) begin
      for (int c = 0; c < DIM; c++) begin
        case (opcode_in)
          OP_MSCALE: ew_res[elem_idx(r, c, DIM)*DW +: DW] =
                       matrix_a_in[elem_idx(r, c, DIM)*DW +: DW] * matrix_b_in[DW-1:0];
          OP_MSUB:   ew_res[elem_idx(r, c, DIM)*DW +: DW] =
                       matrix_a_in[elem_idx(r, c, DIM)*DW +: DW] -
                       matrix_b_in[elem_idx(r, c, DIM)*DW +: DW];
          OP_MADD:   ew_res[elem_idx(r, c, DIM)*DW +: DW] =
                       matrix_a_in[elem_idx(r, c, DIM)*DW +: DW] +
                       matrix_b_in[elem_idx(r, c, DIM)*DW +: DW];
          OP_MTRANS: ew_res[elem_idx(r, c, DIM)*DW +: DW] =
                       matrix_a_in[elem_idx(c, r, DIM)*DW +: DW];
          default:   ew_res[elem_idx(r, c, DIM)*DW +: DW] = '0;
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    valid_d = valid_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          op_d = opcode_in;
          a_d  = matrix_a_in;
          b_d  = matrix_b_in;
          case (opcode_in)
            OP_NOP: ;
            OP_MMULT: begin
              state_d = S_CALC;
              row_d   = '0;
            end
            OP_MSCALE, OP_MSUB, OP_MADD, OP_MTRANS: begin
              res_d   = ew_res;
              err_d   = 1'b0;
              valid_d = 1'b1;
              state_d = S_DONE;
            end
            default: begin
              res_d   = '0;
              err_d   = 1'b1;
              valid_d = 1'b1;
              state_d = S_DONE;
            end
          endcase
        end
      end
      S_CALC: begin
        if (op_q == OP_MMULT) begin
          acc_d[int'(row_q)*DIM*DW +: DIM*DW] = row_res;
          if (row_q == LAST_ROW) begin
            // The last row goes straight into the output alongside the rest.
            res_d   = acc_d;
            err_d   = 1'b0;
            valid_d = 1'b1;
            row_d   = '0;
            state_d = S_DONE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (ready_in) begin
          valid_d = 1'b0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      op_q    <= OP_NOP;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Gated by rst_in so the block never advertises readiness during reset.
  assign ready_out         = rst_in && (state_q == S_IDLE);
  assign valid_out         = valid_q;
  assign err_out           = err_q;
  assign matrix_result_out = res_q;
  assign state_dbg_out     = state_q;

endmodule
